// File: rtl/cmd_tag_arbiter_if.sv
// Command/response bundle between the control-unit requesters, the tag arbiter and the PSL command port.
// Use the master modport on the requester/PSL side and the slave modport on the arbiter.
interface cmd_tag_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int TAG_BITS    = 8,
    parameter int CU_ID_RANGE = 8
);
    logic                             enabled_in;
    logic [NUM_REQ-1:0]               req_valid_in;
    logic [NUM_REQ-1:0]               req_ready_out;
    logic [NUM_REQ*13-1:0]            req_cmd_in;
    logic [NUM_REQ*64-1:0]            req_addr_in;
    logic [NUM_REQ*12-1:0]            req_size_in;
    logic [NUM_REQ*CU_ID_RANGE-1:0]   req_cu_id_in;
    logic                             cmd_valid_out;
    logic [TAG_BITS-1:0]              cmd_tag_out;
    logic [12:0]                      cmd_code_out;
    logic [63:0]                      cmd_addr_out;
    logic [11:0]                      cmd_size_out;
    logic                             credit_return_in;
    logic                             rsp_valid_in;
    logic [TAG_BITS-1:0]              rsp_tag_in;
    logic                             rsp_valid_out;
    logic [TAG_BITS-1:0]              rsp_tag_out;
    logic [CU_ID_RANGE-1:0]           rsp_cu_id_out;
    logic                             init_done_out;
    logic [TAG_BITS:0]                outstanding_out;
    logic                             tag_error_out;

    modport master (
        output enabled_in, req_valid_in, req_cmd_in, req_addr_in, req_size_in, req_cu_id_in,
               credit_return_in, rsp_valid_in, rsp_tag_in,
        input  req_ready_out, cmd_valid_out, cmd_tag_out, cmd_code_out, cmd_addr_out, cmd_size_out,
               rsp_valid_out, rsp_tag_out, rsp_cu_id_out, init_done_out, outstanding_out, tag_error_out
    );

    modport slave (
        input  enabled_in, req_valid_in, req_cmd_in, req_addr_in, req_size_in, req_cu_id_in,
               credit_return_in, rsp_valid_in, rsp_tag_in,
        output req_ready_out, cmd_valid_out, cmd_tag_out, cmd_code_out, cmd_addr_out, cmd_size_out,
               rsp_valid_out, rsp_tag_out, rsp_cu_id_out, init_done_out, outstanding_out, tag_error_out
    );
endinterface

// File: rtl/cmd_tag_arbiter.sv
// Round-robin CAPI command arbiter with credit gating, free-list tag allocation and tag->cu_id response routing.
// Latency: grant combinational, command issued 1 cycle after grant, response routed 1 cycle after rsp_valid_in.
// Backpressure: requests held (req_ready_out=0) while disabled, in INIT, out of credits or out of tags. Option: TAG_DOUBLE_FREE_CHECK_EN.
module cmd_tag_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TAG_COUNT   = 256,
    parameter int TAG_BITS    = 8,
    parameter int CU_ID_RANGE = 8,
    parameter int CMD_CREDITS = 64
) (
    input logic              clock,
    input logic              rstn,
    cmd_tag_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CRD_W = $clog2(CMD_CREDITS + 1);
    localparam int CNT_W = TAG_BITS + 1;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [TAG_BITS-1:0] LAST_TAG = TAG_BITS'(TAG_COUNT - 1);

    logic [0:0]             state_q, state_d;
    logic [TAG_BITS-1:0]    init_tag_q, init_tag_d;
    logic                   init_done_q, init_done_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CRD_W-1:0]       credit_q, credit_d;
    logic [CNT_W-1:0]       out_q, out_d;
    logic [CNT_W-1:0]       fl_cnt_q, fl_cnt_d;
    logic [TAG_BITS-1:0]    fl_rd_q, fl_wr_q;
    logic [TAG_BITS-1:0]    fl_mem [TAG_COUNT];
    logic [CU_ID_RANGE-1:0] owner_mem [TAG_COUNT];

    logic                   cmd_valid_q;
    logic [TAG_BITS-1:0]    cmd_tag_q;
    logic [12:0]            cmd_code_q;
    logic [63:0]            cmd_addr_q;
    logic [11:0]            cmd_size_q;
    logic                   rsp_valid_q;
    logic [TAG_BITS-1:0]    rsp_tag_q;
    logic [CU_ID_RANGE-1:0] rsp_cu_id_q;
    logic                   tag_err_q;

    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       cand;
    logic                   can_grant, grant;
    logic [TAG_BITS-1:0]    pop_tag;
    logic                   rsp_is_alloc, rsp_ok, rsp_bad;
    logic                   push;
    logic [TAG_BITS-1:0]    push_tag;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'(ptr_q + PTR_W'(i));
            if (!win_found && bus.req_valid_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Free count is registered, so a tag freed this cycle is only grantable next cycle.
    assign can_grant = (state_q == ST_RUN) && bus.enabled_in && (fl_cnt_q != '0) && (credit_q != '0);
    assign grant     = can_grant && win_found;
    assign pop_tag   = fl_mem[fl_rd_q];
    assign bus.req_ready_out = grant ? (NUM_REQ'(1) << win_idx) : '0;

`ifdef TAG_DOUBLE_FREE_CHECK_EN
    logic [TAG_COUNT-1:0] alloc_q;
    assign rsp_is_alloc = alloc_q[bus.rsp_tag_in];

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            alloc_q <= '0;
        end else begin
            if (rsp_ok) alloc_q[bus.rsp_tag_in] <= 1'b0;
            if (grant)  alloc_q[pop_tag]        <= 1'b1;
        end
    end
`else
    assign rsp_is_alloc = 1'b1;
`endif

    assign rsp_ok   = bus.rsp_valid_in && (state_q == ST_RUN) && (bus.rsp_tag_in != '0) && rsp_is_alloc;
    assign rsp_bad  = bus.rsp_valid_in && !rsp_ok;
    assign push     = (state_q == ST_INIT) || rsp_ok;
    assign push_tag = (state_q == ST_INIT) ? init_tag_q : bus.rsp_tag_in;

    always_comb begin
        state_d     = state_q;
        init_tag_d  = init_tag_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            init_tag_d = init_tag_q + 1'b1;
            if (init_tag_q == LAST_TAG) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d    = grant ? win_idx : ptr_q;
        fl_cnt_d = fl_cnt_q + CNT_W'(push) - CNT_W'(grant);
        out_d    = out_q + CNT_W'(grant) - CNT_W'(rsp_ok);
        credit_d = credit_q;
        case ({grant, bus.credit_return_in})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01:   credit_d = (credit_q == CRD_W'(CMD_CREDITS)) ? credit_q : credit_q + 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_INIT;
            init_tag_q  <= TAG_BITS'(1);
            init_done_q <= 1'b0;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            credit_q    <= CRD_W'(CMD_CREDITS);
            out_q       <= '0;
            fl_cnt_q    <= '0;
            fl_rd_q     <= '0;
            fl_wr_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_tag_q   <= '0;
            cmd_code_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_size_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_cu_id_q <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_tag_q  <= init_tag_d;
            init_done_q <= init_done_d;
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            out_q       <= out_d;
            fl_cnt_q    <= fl_cnt_d;
            if (push)  fl_wr_q <= fl_wr_q + 1'b1;
            if (grant) fl_rd_q <= fl_rd_q + 1'b1;
            cmd_valid_q <= grant;
            if (grant) begin
                cmd_tag_q  <= pop_tag;
                cmd_code_q <= bus.req_cmd_in[win_idx*13 +: 13];
                cmd_addr_q <= bus.req_addr_in[win_idx*64 +: 64];
                cmd_size_q <= bus.req_size_in[win_idx*12 +: 12];
            end
            rsp_valid_q <= rsp_ok;
            if (rsp_ok) begin
                rsp_tag_q   <= bus.rsp_tag_in;
                rsp_cu_id_q <= owner_mem[bus.rsp_tag_in];
            end
            tag_err_q <= tag_err_q | rsp_bad;
        end
    end

    // Storage arrays need no reset: INIT rewrites the pool and owners are written before use.
    always_ff @(posedge clock) begin
        if (push)  fl_mem[fl_wr_q]    <= push_tag;
        if (grant) owner_mem[pop_tag] <= bus.req_cu_id_in[win_idx*CU_ID_RANGE +: CU_ID_RANGE];
    end

    assign bus.cmd_valid_out   = cmd_valid_q;
    assign bus.cmd_tag_out     = cmd_tag_q;
    assign bus.cmd_code_out    = cmd_code_q;
    assign bus.cmd_addr_out    = cmd_addr_q;
    assign bus.cmd_size_out    = cmd_size_q;
    assign bus.rsp_valid_out   = rsp_valid_q;
    assign bus.rsp_tag_out     = rsp_tag_q;
    assign bus.rsp_cu_id_out   = rsp_cu_id_q;
    assign bus.init_done_out   = init_done_q;
    assign bus.outstanding_out = out_q;
    assign bus.tag_error_out   = tag_err_q;
endmodule

// File: tb/tb_cmd_tag_arbiter.sv
// Directed bench for cmd_tag_arbiter: scoreboard queues hold expected commands/responses, monitors pop on DUT output.
module tb_cmd_tag_arbiter;
    localparam int NR = 4;
    localparam int TB = 8;
    localparam int CU = 8;

    logic clock = 1'b0;
    logic rstn  = 1'b0;
    always #5 clock = ~clock;

    cmd_tag_arbiter_if #(.NUM_REQ(NR), .TAG_BITS(TB), .CU_ID_RANGE(CU)) bus ();

    cmd_tag_arbiter #(
        .NUM_REQ(NR), .TAG_COUNT(256), .TAG_BITS(TB), .CU_ID_RANGE(CU), .CMD_CREDITS(64)
    ) dut (
        .clock(clock),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [7:0]  tag;
        logic [12:0] code;
        logic [63:0] addr;
        logic [11:0] size;
    } cmd_exp_t;

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] cu;
    } rsp_exp_t;

    cmd_exp_t   cmd_q[$];
    rsp_exp_t   rsp_q[$];
    int         free_q[$];
    logic [7:0] owner [256];
    logic       alloc [256];
    int         exp_out;
    int         last_win;
    int         stepno;
    int         checks = 0;
    int         errors = 0;
    cmd_exp_t   mon_c;
    rsp_exp_t   mon_r;

    function automatic logic [12:0] f_code(int r);
        return 13'(13'h100 + r);
    endfunction
    function automatic logic [63:0] f_addr(int r, int s);
        return {24'hADD000, 8'(r), 32'(s)};
    endfunction
    function automatic logic [11:0] f_size(int r, int s);
        return 12'(16 * (r + 1) + (s % 16));
    endfunction
    function automatic logic [7:0] f_cu(int r);
        return 8'(8'h10 + r);
    endfunction
    function automatic int nxt();
        return (last_win + 1) % NR;
    endfunction

    function automatic logic rsp_accepted(logic [7:0] t);
`ifdef TAG_DOUBLE_FREE_CHECK_EN
        return (t != 8'd0) && alloc[t];
`else
        return t != 8'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Output monitors: every DUT command/response must match the oldest expectation.
    always @(negedge clock) begin
        if (rstn && bus.cmd_valid_out) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
            else begin
                mon_c = cmd_q.pop_front();
                chk("cmd_tag",  bus.cmd_tag_out,  mon_c.tag);
                chk("cmd_code", bus.cmd_code_out, mon_c.code);
                chk("cmd_addr", bus.cmd_addr_out, mon_c.addr);
                chk("cmd_size", bus.cmd_size_out, mon_c.size);
            end
        end
        if (rstn && bus.rsp_valid_out) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
            else begin
                mon_r = rsp_q.pop_front();
                chk("rsp_tag",   bus.rsp_tag_out,   mon_r.tag);
                chk("rsp_cu_id", bus.rsp_cu_id_out, mon_r.cu);
            end
        end
    end

    task automatic drive_payload(input int s);
        for (int r = 0; r < NR; r++) begin
            bus.req_cmd_in[r*13 +: 13]  = f_code(r);
            bus.req_addr_in[r*64 +: 64] = f_addr(r, s);
            bus.req_size_in[r*12 +: 12] = f_size(r, s);
            bus.req_cu_id_in[r*8 +: 8]  = f_cu(r);
        end
    endtask

    // One cycle: drive at negedge, check the combinational grant, record expectations, advance.
    task automatic step(input logic [3:0] vld, input logic cr, input logic rv, input logic [7:0] rt, input int win);
        int       tag;
        cmd_exp_t ce;
        rsp_exp_t re;
        bus.req_valid_in     = vld;
        bus.credit_return_in = cr;
        bus.rsp_valid_in     = rv;
        bus.rsp_tag_in       = rt;
        drive_payload(stepno);
        #1;
        chk("req_ready", bus.req_ready_out, (win >= 0) ? (64'd1 << win) : 64'd0);
        if (win >= 0) begin
            tag        = free_q.pop_front();
            owner[tag] = f_cu(win);
            alloc[tag] = 1'b1;
            ce.tag  = 8'(tag);
            ce.code = f_code(win);
            ce.addr = f_addr(win, stepno);
            ce.size = f_size(win, stepno);
            cmd_q.push_back(ce);
            exp_out++;
            last_win = win;
        end
        if (rv && rsp_accepted(rt)) begin
            re.tag = rt;
            re.cu  = owner[rt];
            rsp_q.push_back(re);
            free_q.push_back(int'(rt));
            alloc[rt] = 1'b0;
            exp_out--;
        end
        @(negedge clock);
        stepno++;
    endtask

    task automatic reset_check(input string tagname);
        chk({tagname, "_cmd_valid"},   bus.cmd_valid_out,   0);
        chk({tagname, "_rsp_valid"},   bus.rsp_valid_out,   0);
        chk({tagname, "_init_done"},   bus.init_done_out,   0);
        chk({tagname, "_outstanding"}, bus.outstanding_out, 0);
        chk({tagname, "_tag_error"},   bus.tag_error_out,   0);
        chk({tagname, "_req_ready"},   bus.req_ready_out,   0);
    endtask

    // Release reset at a negedge, clear the model and time the pool fill.
    task automatic do_init();
        int cyc;
        cmd_q.delete();
        rsp_q.delete();
        free_q.delete();
        for (int t = 1; t < 256; t++) begin
            free_q.push_back(t);
            alloc[t] = 1'b0;
        end
        exp_out  = 0;
        last_win = NR - 1;
        rstn = 1'b1;
        cyc  = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            cyc++;
            if (cyc == 100) chk("no_grant_in_init", bus.req_ready_out, 0);
            if (bus.init_done_out) break;
        end
        chk("init_cycles", cyc, 255);
        chk("init_outstanding", bus.outstanding_out, 0);
        chk("init_tag_error", bus.tag_error_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int w;
        stepno                = 0;
        bus.enabled_in        = 1'b1;
        bus.req_valid_in      = 4'hF;
        bus.credit_return_in  = 1'b0;
        bus.rsp_valid_in      = 1'b0;
        bus.rsp_tag_in        = '0;
        drive_payload(0);
        #12;
        reset_check("reset");
        @(negedge clock);
        do_init();

        // enable gating, then round-robin order 0,1,2,3,0 with tags 1..5
        bus.enabled_in = 1'b0;
        step(4'hF, 0, 0, 8'd0, -1);
        bus.enabled_in = 1'b1;
        for (int i = 0; i < 5; i++) step(4'hF, 0, 0, 8'd0, i % NR);
        step(4'b0100, 0, 1, 8'd3, 2);
        step(4'h0, 0, 0, 8'd0, -1);
        chk("outstanding_rr", bus.outstanding_out, 64'(exp_out));

        // 64 credits consumed in total, then stall; one credit return lets exactly one more go
        for (int i = 0; i < 58; i++) step(4'hF, 0, 0, 8'd0, nxt());
        for (int i = 0; i < 3; i++)  step(4'hF, 0, 0, 8'd0, -1);
        step(4'hF, 1, 0, 8'd0, -1);
        step(4'hF, 0, 0, 8'd0, nxt());
        step(4'hF, 0, 0, 8'd0, -1);
        step(4'hF, 0, 0, 8'd0, -1);
        chk("outstanding_credits", bus.outstanding_out, 64'(exp_out));

        // exhaust the tag pool while credits keep coming back
        step(4'hF, 1, 0, 8'd0, -1);
        n = free_q.size();
        for (int i = 0; i < n; i++) step(4'hF, 1, 0, 8'd0, nxt());
        step(4'hF, 1, 0, 8'd0, -1);
        step(4'hF, 1, 0, 8'd0, -1);
        chk("outstanding_full", bus.outstanding_out, 255);
        step(4'hF, 1, 1, 8'd17, -1);
        step(4'hF, 1, 0, 8'd0, nxt());
        step(4'hF, 0, 0, 8'd0, -1);
        step(4'h0, 0, 0, 8'd0, -1);
        chk("outstanding_refill", bus.outstanding_out, 255);

        // duplicate response to tag 5, then an illegal tag 0
        step(4'h0, 0, 1, 8'd5, -1);
        step(4'h0, 0, 1, 8'd5, -1);
        step(4'h0, 0, 0, 8'd0, -1);
`ifdef TAG_DOUBLE_FREE_CHECK_EN
        chk("double_free_error", bus.tag_error_out, 1);
`else
        chk("double_free_no_error", bus.tag_error_out, 0);
`endif
        chk("outstanding_dfree", bus.outstanding_out, 64'(exp_out));
        step(4'h0, 0, 1, 8'd0, -1);
        chk("tag0_no_rsp", bus.rsp_valid_out, 0);
        step(4'h0, 0, 0, 8'd0, -1);
        chk("tag0_error", bus.tag_error_out, 1);
        chk("tag0_outstanding", bus.outstanding_out, 64'(exp_out));

        // fresh start, ten tags in flight, then asynchronous reset with a command on the bus
        rstn = 1'b0;
        #1;
        reset_check("reset2");
        @(negedge clock);
        do_init();
        for (int i = 0; i < 9; i++) step(4'hF, 0, 0, 8'd0, nxt());
        w = nxt();
        bus.req_valid_in = 4'hF;
        #1;
        chk("req_ready_10th", bus.req_ready_out, 64'd1 << w);
        @(posedge clock);
        #2;
        chk("cmd_in_flight", bus.cmd_valid_out, 1);
        chk("outstanding_10", bus.outstanding_out, 10);
        rstn = 1'b0;
        #1;
        reset_check("async_reset");
        @(negedge clock);
        do_init();
        step(4'hF, 0, 0, 8'd0, 0);
        step(4'h0, 0, 0, 8'd0, -1);
        chk("outstanding_after_reinit", bus.outstanding_out, 1);
        chk("cmd_queue_drained", 64'(cmd_q.size()), 0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_tag_arbiter.md
Name: cmd_tag_arbiter

Overview:
- Shares the single CAPI command port between the command-generating control units: vertex control, edge data read, edge data write and prefetch.
- Round-robin arbitration across requesters, gated by available command credits.
- Allocates a unique command tag per issued command from a free-list pool.
- Records which cu_id owns each tag; on response, returns the tag to the pool and reports the owning cu_id for response routing.

Parameters:
NUM_REQ, 4, number of requesters (power of 2, 2..8)
TAG_COUNT, 256, tag space size; tag 0 (INVALID_TAG) is never issued, so 255 tags are usable
TAG_BITS, 8, width of tag, equal to $clog2(TAG_COUNT)
CU_ID_RANGE, 8, width of cu_id
CMD_CREDITS, 64, command credits available after reset (PSL room)

Ports:
clock  in  1  system clock
rstn  in  1  asynchronous active-low reset
enabled_in  in  1  arbitration enable; 0 blocks new grants, responses still processed
req_valid_in  in  NUM_REQ  per-requester command request
req_ready_out  out  NUM_REQ  one-hot grant, same cycle as request
req_cmd_in  in  NUM_REQ*13  command codes, requester i at slice i
req_addr_in  in  NUM_REQ*64  effective addresses
req_size_in  in  NUM_REQ*12  byte sizes
req_cu_id_in  in  NUM_REQ*CU_ID_RANGE  issuing cu_id
cmd_valid_out  out  1  command issued to PSL
cmd_tag_out  out  TAG_BITS  allocated tag
cmd_code_out  out  13  command code
cmd_addr_out  out  64  address
cmd_size_out  out  12  size
credit_return_in  in  1  one credit returned by PSL
rsp_valid_in  in  1  PSL response strobe
rsp_tag_in  in  TAG_BITS  response tag
rsp_valid_out  out  1  routed response strobe
rsp_tag_out  out  TAG_BITS  response tag
rsp_cu_id_out  out  CU_ID_RANGE  owner of the responding tag
init_done_out  out  1  tag pool filled
outstanding_out  out  TAG_BITS+1  tags currently allocated
tag_error_out  out  1  sticky: illegal response tag

Behaviour:
- Reset: all outputs 0; credit count = CMD_CREDITS; round-robin pointer = NUM_REQ-1, so requester 0 wins first; FSM enters INIT; tag_error_out is cleared.
- INIT state:
  - Pushes tags 1..TAG_COUNT-1 into the free-list FIFO, one per cycle (255 cycles).
  - Then moves to RUN and asserts init_done_out, which stays high until reset.
  - No grants during INIT.
  - rsp_valid_in during INIT is ignored and sets tag_error_out.
- RUN grant condition: enabled_in=1, free list non-empty, credit count > 0, and at least one req_valid_in set.
  - Winner is the first valid requester searching from pointer+1, wrapping modulo NUM_REQ.
  - req_ready_out[winner]=1, combinational, in the same cycle.
  - The pointer updates to the winner.
- Issue:
  - Cycle after the grant: cmd_valid_out=1 for exactly 1 cycle, with the winner's cmd/addr/size and the popped tag.
  - At most one command per cycle; full throughput is 1 command per cycle.
  - Tag table[tag] <= winner's cu_id on grant.
- Credits:
  - Decrement on grant, increment on credit_return_in.
  - Both in the same cycle: unchanged.
  - Increment saturates at CMD_CREDITS.
  - Credit count 0: no grant, requests held.
- Response:
  - rsp_valid_in with tag T: the next cycle drives rsp_valid_out=1, rsp_tag_out=T, rsp_cu_id_out=table[T].
  - T is pushed to the free list in the same cycle.
  - T=0: no push, no rsp_valid_out, tag_error_out set.
- outstanding_out = allocations minus frees.
  - Simultaneous grant and free: net unchanged.
  - A tag freed this cycle becomes grantable next cycle, never the same cycle.
- Free list empty (255 outstanding): no grant until a response frees a tag.
- Reset mid-operation: all in-flight tags are discarded, the pool is re-initialised and INIT is re-run.

Optional Feature:
TAG_DOUBLE_FREE_CHECK_EN
- Defined: keep a per-tag allocated bit, set on grant and cleared on response.
  - A response to a tag whose bit is clear is dropped: no push, no rsp_valid_out, tag_error_out set.
  - This prevents free-list corruption from duplicate or stray responses.
- Undefined: no allocated bits.
  - Any nonzero response tag is pushed and routed.
  - Double frees are undetected.

Test Plan:
- Reset then idle: init_done_out rises exactly 255 cycles after rstn deasserts; outstanding_out=0; no cmd_valid_out.
- All 4 requesters valid continuously, enabled=1: grants in order 0,1,2,3,0; tags 1,2,3,4,5 issued on consecutive cycles; rsp_tag=3 returns rsp_cu_id of requester 2.
- CMD_CREDITS=64, no credit returns: 64 commands issue, then requests stall.
  - One credit_return_in pulse: exactly one more command issues.
- Hold 255 tags outstanding with credits returned:
  - 256th request is stalled with req_ready=0.
  - rsp_tag=17 lets tag 17 issue 2 cycles later.
- rsp_valid_in with tag 0: tag_error_out=1, no rsp_valid_out.
  - With TAG_DOUBLE_FREE_CHECK_EN, a second response to the same tag 5: dropped, error set.
- rstn pulsed low with 10 tags outstanding: outputs clear asynchronously, INIT re-runs, first grant receives tag 1.
